// File: rtl/softmax_q610_pkg.sv
// Shared constants and state encoding for the Q6.10 softmax-approximation pipeline.
// STAGE4_SUM_SAT_EN narrows the stage-4 frame-sum output to DATA_W bits (saturating).
package softmax_q610_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 10;
  localparam int MAX_LEN = 64;
  localparam int IDX_W   = $clog2(MAX_LEN);
  localparam int SUM_W   = DATA_W + IDX_W;

`ifdef STAGE4_SUM_SAT_EN
  localparam int SUM_OUT_W = DATA_W;
`else
  localparam int SUM_OUT_W = SUM_W;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/stage4_bank_ram.sv
// Ping-pong frame buffer: two banks of MAX_LEN words, addressed {bank, idx}.
// Synchronous write, combinational read.
module stage4_bank_ram
  import softmax_q610_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W:0]    waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W:0]    raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2*MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stage4_pow2_accum.sv
// Softmax stage 4: accumulate per-frame sum of 2^x values, buffer the frame, replay it with its sum.
// STAGE4_SUM_SAT_EN: sum_out is DATA_W wide and saturates at 2^DATA_W-1.
module stage4_pow2_accum
  import softmax_q610_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic                 last_in,
  input  logic [DATA_W-1:0]    pow_in,
  output logic                 valid_out,
  output logic                 last_out,
  output logic [DATA_W-1:0]    pow_out,
  output logic [SUM_OUT_W-1:0] sum_out,
  output logic                 overflow
);

  function automatic logic [SUM_OUT_W-1:0] fmt_sum(input logic [SUM_W-1:0] s);
`ifdef STAGE4_SUM_SAT_EN
    if (|s[SUM_W-1:DATA_W]) return '1;
    return s[DATA_W-1:0];
`else
    return s;
`endif
  endfunction

  drain_state_e          state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [SUM_W-1:0]      acc_q, acc_d;
  logic                  drop_q, drop_d;
  logic                  overflow_q, overflow_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic [SUM_W-1:0]      bank_sum_q [2];
  logic [SUM_W-1:0]      bank_sum_d [2];
  logic [IDX_W-1:0]      bank_last_q [2];
  logic [IDX_W-1:0]      bank_last_d [2];
  logic                  valid_out_q, valid_out_d;
  logic                  last_out_q, last_out_d;
  logic [DATA_W-1:0]     pow_out_q, pow_out_d;
  logic [SUM_OUT_W-1:0]  sum_out_q, sum_out_d;

  logic                  ram_we;
  logic                  frame_end;
  logic                  emit;
  logic                  emit_last;
  logic [DATA_W-1:0]     ram_rdata;

  stage4_bank_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({wr_bank_q, wr_idx_q}),
    .wdata (pow_in),
    .raddr ({rd_bank_q, rd_idx_q}),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    acc_d       = acc_q;
    drop_d      = drop_q;
    overflow_d  = overflow_q;
    bank_full_d = bank_full_q;
    bank_sum_d  = bank_sum_q;
    bank_last_d = bank_last_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    pow_out_d   = pow_out_q;
    sum_out_d   = sum_out_q;
    ram_we      = 1'b0;
    frame_end   = 1'b0;
    emit        = 1'b0;
    emit_last   = 1'b0;

    if (en) begin
      // Fill side: a frame may only start in a bank the reader has already released.
      if (valid_in) begin
        if (drop_q) begin
          if (last_in) drop_d = 1'b0;
        end else if ((wr_idx_q == '0) && bank_full_q[wr_bank_q]) begin
          overflow_d = 1'b1;
          drop_d     = !last_in;
        end else begin
          ram_we    = 1'b1;
          frame_end = last_in || (wr_idx_q == IDX_W'(MAX_LEN - 1));
          if (frame_end) begin
            bank_sum_d[wr_bank_q]  = acc_q + SUM_W'(pow_in);
            bank_last_d[wr_bank_q] = wr_idx_q;
            bank_full_d[wr_bank_q] = 1'b1;
            acc_d                  = '0;
            wr_idx_d               = '0;
            wr_bank_d              = ~wr_bank_q;
          end else begin
            acc_d    = acc_q + SUM_W'(pow_in);
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end

      // Drain side: IDLE starts on a full bank and emits element 0 on the same edge.
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;
      emit        = (state_q == ST_DRAIN) || bank_full_q[rd_bank_q];
      if (emit) begin
        emit_last   = (rd_idx_q == bank_last_q[rd_bank_q]);
        valid_out_d = 1'b1;
        last_out_d  = emit_last;
        pow_out_d   = ram_rdata;
        sum_out_d   = fmt_sum(bank_sum_q[rd_bank_q]);
        if (emit_last) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = ~rd_bank_q;
          rd_idx_d               = '0;
          state_d                = bank_full_q[~rd_bank_q] ? ST_DRAIN : ST_IDLE;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
          state_d  = ST_DRAIN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      acc_q       <= '0;
      drop_q      <= 1'b0;
      overflow_q  <= 1'b0;
      bank_full_q <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      pow_out_q   <= '0;
      sum_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      acc_q       <= acc_d;
      drop_q      <= drop_d;
      overflow_q  <= overflow_d;
      bank_full_q <= bank_full_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      pow_out_q   <= pow_out_d;
      sum_out_q   <= sum_out_d;
    end
  end

  // Per-bank frame descriptors are only meaningful while bank_full is set.
  always_ff @(posedge clk) begin
    bank_sum_q  <= bank_sum_d;
    bank_last_q <= bank_last_d;
  end

  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;
  assign pow_out   = pow_out_q;
  assign sum_out   = sum_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_stage4_pow2_accum.sv
// Directed bench for stage4_pow2_accum: cycle table plus scoreboarded multi-frame sequences.
// STAGE4_SUM_SAT_EN adds the saturated-sum sequence.
module tb_stage4_pow2_accum;
  import softmax_q610_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, en, valid_in, last_in;
  logic [DATA_W-1:0]    pow_in;
  logic                 valid_out, last_out, overflow;
  logic [DATA_W-1:0]    pow_out;
  logic [SUM_OUT_W-1:0] sum_out;

  stage4_pow2_accum dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .pow_in    (pow_in),
    .valid_out (valid_out),
    .last_out  (last_out),
    .pow_out   (pow_out),
    .sum_out   (sum_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              en, v, l;
    logic [DATA_W-1:0] p;
    logic              ev, el;
    logic [DATA_W-1:0] ep;
    logic [31:0]       es;
    logic              eo;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] pow;
    logic [31:0]       sum;
    logic              last;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   first_v = -1;
  int   last_v = -1;
  int   n_out = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic add(input int e, v, l, p, ev, el, ep, es, eo);
    vec_t t;
    t.en = e[0]; t.v = v[0]; t.l = l[0]; t.p = p[DATA_W-1:0];
    t.ev = ev[0]; t.el = el[0]; t.ep = ep[DATA_W-1:0]; t.es = es; t.eo = eo[0];
    tbl.push_back(t);
  endtask

  task automatic push(input int p, s, l);
    exp_t x;
    x.pow = p[DATA_W-1:0]; x.sum = s; x.last = l[0];
    exp_q.push_back(x);
  endtask

  task automatic drive(input int e, v, l, p);
    exp_t x;
    en = e[0]; valid_in = v[0]; last_in = l[0]; pow_in = p[DATA_W-1:0];
    step();
    if (valid_out) begin
      n_out++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got pow %0h sum %0h last %0b, required no output",
                 pow_out, sum_out, last_out);
      end else begin
        x = exp_q.pop_front();
        if (pow_out !== x.pow || 32'(sum_out) !== x.sum || last_out !== x.last) begin
          n_bad++;
          $display("FAIL out_elem: got pow %0h sum %0h last %0b, required pow %0h sum %0h last %0b",
                   pow_out, sum_out, last_out, x.pow, x.sum, x.last);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid_in = 1'b0; last_in = 1'b0; pow_in = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(valid_out), 0);
    check("rst_last", 32'(last_out), 0);
    check("rst_pow", 32'(pow_out), 0);
    check("rst_sum", 32'(sum_out), 0);
    check("rst_ovf", 32'(overflow), 0);

    // en, v, l, pow, exp_valid, exp_last, exp_pow, exp_sum, exp_ovf
    add(1, 1, 0, 'h400, 0, 0, 'h000, 'h0000, 0);
    add(1, 1, 0, 'h400, 0, 0, 'h000, 'h0000, 0);
    add(1, 1, 0, 'h400, 0, 0, 'h000, 'h0000, 0);
    add(1, 1, 1, 'h400, 0, 0, 'h000, 'h0000, 0);
    add(1, 0, 0, 'h000, 1, 0, 'h400, 'h1000, 0);
    add(1, 0, 0, 'h000, 1, 0, 'h400, 'h1000, 0);
    add(1, 0, 0, 'h000, 1, 0, 'h400, 'h1000, 0);
    add(1, 0, 0, 'h000, 1, 1, 'h400, 'h1000, 0);
    add(1, 0, 0, 'h000, 0, 0, 'h400, 'h1000, 0);
    add(1, 1, 0, 'h400, 0, 0, 'h400, 'h1000, 0);
    add(1, 1, 1, 'h800, 0, 0, 'h400, 'h1000, 0);
    add(1, 1, 1, 'h200, 1, 0, 'h400, 'h0C00, 0);
    add(1, 0, 0, 'h000, 1, 1, 'h800, 'h0C00, 0);
    add(1, 0, 0, 'h000, 1, 1, 'h200, 'h0200, 0);
    add(1, 0, 0, 'h000, 0, 0, 'h200, 'h0200, 0);
    add(1, 1, 0, 'h100, 0, 0, 'h200, 'h0200, 0);
    add(1, 1, 0, 'h200, 0, 0, 'h200, 'h0200, 0);
    add(1, 1, 1, 'h300, 0, 0, 'h200, 'h0200, 0);
    add(1, 0, 0, 'h000, 1, 0, 'h100, 'h0600, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 'hFFF, 1, 0, 'h100, 'h0600, 0);
    add(1, 0, 0, 'h000, 1, 0, 'h200, 'h0600, 0);
    add(1, 0, 0, 'h000, 1, 1, 'h300, 'h0600, 0);
    add(1, 0, 0, 'h000, 0, 0, 'h300, 'h0600, 0);
    add(1, 0, 0, 'h000, 0, 0, 'h300, 'h0600, 0);
    add(1, 0, 0, 'h000, 0, 0, 'h300, 'h0600, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; valid_in = tbl[i].v; last_in = tbl[i].l; pow_in = tbl[i].p;
      step();
      check($sformatf("row%0d_valid", i), 32'(valid_out), 32'(tbl[i].ev));
      check($sformatf("row%0d_last", i), 32'(last_out), 32'(tbl[i].el));
      check($sformatf("row%0d_pow", i), 32'(pow_out), 32'(tbl[i].ep));
      check($sformatf("row%0d_sum", i), 32'(sum_out), tbl[i].es);
      check($sformatf("row%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
    end

    // Len-8 frame, len-1 frame, then a third frame that finds its bank still full.
    for (int k = 1; k <= 8; k++) begin
      push(k * 'h10, 'h240, (k == 8) ? 1 : 0);
      drive(1, 1, (k == 8) ? 1 : 0, k * 'h10);
    end
    push('h777, 'h777, 1);
    drive(1, 1, 1, 'h777);
    check("t3_ovf_before", 32'(overflow), 0);
    drive(1, 1, 0, 'h1111);
    check("t3_ovf_set", 32'(overflow), 1);
    drive(1, 1, 0, 'h2222);
    drive(1, 1, 1, 'h3333);
    idle(20);
    check("t3_drained", 32'(exp_q.size()), 0);
    check("t3_ovf_sticky", 32'(overflow), 1);
    push('h5, 'h5, 1);
    drive(1, 1, 1, 'h5);
    idle(5);
    check("t3_after_drop", 32'(exp_q.size()), 0);

    // Reset in the middle of a replay discards the rest of it.
    for (int k = 0; k < 4; k++) drive(1, 1, (k == 3) ? 1 : 0, 'h400);
    push('h400, 'h1000, 0);
    push('h400, 'h1000, 0);
    idle(2);
    check("t6_pre_rst", 32'(exp_q.size()), 0);
    rst = 1'b1;
    drive(1, 0, 0, 0);
    rst = 1'b0;
    check("t6_valid", 32'(valid_out), 0);
    check("t6_last", 32'(last_out), 0);
    check("t6_pow", 32'(pow_out), 0);
    check("t6_sum", 32'(sum_out), 0);
    check("t6_ovf", 32'(overflow), 0);
    idle(10);
    push('h123, 'h579, 0);
    push('h456, 'h579, 1);
    drive(1, 1, 0, 'h123);
    drive(1, 1, 1, 'h456);
    idle(5);
    check("t6_fresh", 32'(exp_q.size()), 0);

    // MAX_LEN+2 ones: forced end after MAX_LEN, remainder is its own frame.
    n_out = 0; first_v = -1; last_v = -1;
    for (int i = 0; i < MAX_LEN; i++) push(1, MAX_LEN, (i == MAX_LEN - 1) ? 1 : 0);
    push(1, 2, 0);
    push(1, 2, 1);
    for (int i = 0; i < MAX_LEN + 2; i++) drive(1, 1, (i == MAX_LEN + 1) ? 1 : 0, 1);
    idle(MAX_LEN + 16);
    check("t4_count", 32'(n_out), MAX_LEN + 2);
    check("t4_no_gap", 32'(last_v - first_v), MAX_LEN + 1);
    check("t4_drained", 32'(exp_q.size()), 0);
    check("t4_ovf", 32'(overflow), 0);

`ifdef STAGE4_SUM_SAT_EN
    rst = 1'b1;
    drive(1, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) push('h800, 'hFFFF, (i == MAX_LEN - 1) ? 1 : 0);
    for (int i = 0; i < MAX_LEN; i++) drive(1, 1, (i == MAX_LEN - 1) ? 1 : 0, 'h800);
    idle(MAX_LEN + 8);
    check("sat_drained", 32'(exp_q.size()), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
